alu_decode_stage: RTL and testbench

//  Decode/operand-fetch stage sitting directly upstream of the ALU. Accepts RV32I
//  OP (0110011) and OP-IMM (0010011) instructions over valid/ready, reads operands

---
 rtl/alu_decode_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode_stage
// Purpose  : Decode / operand-fetch stage in front of the ALU. Accepts RV32I
//            OP and OP-IMM instructions over valid/ready and reads operands
//            from an internal register file (x0 is hard-wired to zero). It
//            hands ALU-ready operands downstream through a 2-entry elastic
//            buffer. Other opcodes, and OP/OP-IMM encodings with bad func7,
//            are consumed and flagged on illegal_o.
// Ports    : clk_i / rst_ni        clock, asynchronous active-low reset
//            flush_i               drop every buffered entry
//            inst_i / inst_valid_i / inst_ready_o   instruction handshake
//            wb_en_i / wb_addr_i / wb_data_i        register writeback
//            data1_o / data2_o / opcode_o / func3_o / func7_o / rd_o
//                                  operands and control towards the ALU
//            valid_o / ready_i     downstream handshake
//            illegal_o             one-cycle pulse for an undecodable instr
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode_stage #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_REGS      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [31:0]              inst_i,
    input  logic                     inst_valid_i,
    output logic                     inst_ready_o,
    input  logic                     wb_en_i,
    input  logic [4:0]               wb_addr_i,
    input  logic [REGISTER_SIZE-1:0] wb_data_i,
    output logic [REGISTER_SIZE-1:0] data1_o,
    output logic [REGISTER_SIZE-1:0] data2_o,
    output logic [6:0]               opcode_o,
    output logic [2:0]               func3_o,
    output logic [6:0]               func7_o,
    output logic [4:0]               rd_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     illegal_o
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM    = 7'b0010011;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_ONE     = 2'd1;
    localparam logic [1:0] c_ST_TWO     = 2'd2;

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] data1;
        logic [REGISTER_SIZE-1:0] data2;
        logic [2:0]               func3;
        logic [6:0]               func7;
        logic [4:0]               rd;
    } entry_t;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_func3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_func7;
    logic       w_is_op;
    logic       w_is_imm;
    logic       w_is_shift;

    assign w_opcode   = inst_i[6:0];
    assign w_rd       = inst_i[11:7];
    assign w_func3    = inst_i[14:12];
    assign w_rs1      = inst_i[19:15];
    assign w_rs2      = inst_i[24:20];
    assign w_func7    = inst_i[31:25];
    assign w_is_op    = (w_opcode == c_OPC_OP);
    assign w_is_imm   = (w_opcode == c_OPC_IMM);
    // For OP-IMM shifts the upper immediate bits act as func7.
    assign w_is_shift = w_is_imm && ((w_func3 == 3'b001) || (w_func3 == 3'b101));

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [REGISTER_SIZE-1:0] r_regs [NUM_REGS];
    logic [REGISTER_SIZE-1:0] w_rs1_val;
    logic [REGISTER_SIZE-1:0] w_rs2_val;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Reads see a same-cycle writeback so the producer need not stall.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != 5'd0) begin
            w_rs1_val = (wb_en_i && (wb_addr_i == w_rs1)) ? wb_data_i : r_regs[w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            w_rs2_val = (wb_en_i && (wb_addr_i == w_rs2)) ? wb_data_i : r_regs[w_rs2];
        end
    end

    // ------------------------------------------------------------------
    // Legality and new-entry formation
    // ------------------------------------------------------------------
    logic   w_illegal;
    entry_t w_new;

    always_comb begin
        w_illegal = 1'b1;
        if (w_is_op) begin
            // Only base ops (func7=0) and SUB/SRA (func7=0100000) exist.
            w_illegal = !((w_func7 == 7'd0) ||
                          ((w_func7 == c_F7_ALT) &&
                           ((w_func3 == 3'b000) || (w_func3 == 3'b101))));
        end else if (w_is_imm) begin
            if (w_func3 == 3'b001) begin
                w_illegal = (w_func7 != 7'd0);
            end else if (w_func3 == 3'b101) begin
                w_illegal = !((w_func7 == 7'd0) || (w_func7 == c_F7_ALT));
            end else begin
                w_illegal = 1'b0;
            end
        end
    end

    always_comb begin
        w_new       = '0;
        w_new.data1 = w_rs1_val;
        w_new.data2 = w_is_op ? w_rs2_val
                              : {{(REGISTER_SIZE-12){inst_i[31]}}, inst_i[31:20]};
        w_new.func3 = w_func3;
        w_new.func7 = (w_is_op || w_is_shift) ? w_func7 : 7'd0;
        w_new.rd    = w_rd;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_accept = inst_valid_i && inst_ready_o;
    assign w_push   = w_accept && !w_illegal && !flush_i;
    assign w_pop    = valid_o && ready_i;

    // ------------------------------------------------------------------
    // Buffer FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_push) w_state_next = c_ST_ONE;
            c_ST_ONE: begin
                if (w_push && !w_pop)      w_state_next = c_ST_TWO;
                else if (w_pop && !w_push) w_state_next = c_ST_EMPTY;
            end
            c_ST_TWO:   if (w_pop) w_state_next = c_ST_ONE;
            default:    w_state_next = c_ST_EMPTY;
        endcase
        if (flush_i) begin
            w_state_next = c_ST_EMPTY;
        end
    end

    always_comb begin
        valid_o      = (r_state == c_ST_ONE) || (r_state == c_ST_TWO);
        inst_ready_o = (r_state != c_ST_TWO);
        opcode_o     = valid_o ? c_OPC_OP : 7'd0;
    end

    // ------------------------------------------------------------------
    // Head / skid storage. Head always drives the ALU; the skid slot
    // only fills when a push arrives while the head is stalled.
    // ------------------------------------------------------------------
    entry_t r_head;
    entry_t r_skid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: if (w_push) r_head <= w_new;
                c_ST_ONE: begin
                    if (w_push) begin
                        if (w_pop) r_head <= w_new;
                        else       r_skid <= w_new;
                    end
                end
                c_ST_TWO:   if (w_pop) r_head <= r_skid;
                default:    ;
            endcase
        end
    end

    assign data1_o = r_head.data1;
    assign data2_o = r_head.data2;
    assign func3_o = r_head.func3;
    assign func7_o = r_head.func7;
    assign rd_o    = r_head.rd;

    // ------------------------------------------------------------------
    // Illegal pulse
    // ------------------------------------------------------------------
    logic r_illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_illegal && !flush_i;
        end
    end

    assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_decode_stage
// Purpose  : Self-checking bench for alu_decode_stage. Directed scenarios
//            followed by randomized traffic, all checked cycle by cycle
//            against a queue-based reference model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_decode_stage;

    localparam logic [6:0] c_OPC_OP  = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM = 7'b0010011;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        r_rst_n;
    logic        r_flush;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic        r_wb_en;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_ready;
    logic        w_inst_ready;
    logic [31:0] w_data1;
    logic [31:0] w_data2;
    logic [6:0]  w_opcode;
    logic [2:0]  w_func3;
    logic [6:0]  w_func7;
    logic [4:0]  w_rd;
    logic        w_valid;
    logic        w_illegal;

    alu_decode_stage #(
        .REGISTER_SIZE (32),
        .NUM_REGS      (32)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (r_rst_n),
        .flush_i      (r_flush),
        .inst_i       (r_inst),
        .inst_valid_i (r_inst_valid),
        .inst_ready_o (w_inst_ready),
        .wb_en_i      (r_wb_en),
        .wb_addr_i    (r_wb_addr),
        .wb_data_i    (r_wb_data),
        .data1_o      (w_data1),
        .data2_o      (w_data2),
        .opcode_o     (w_opcode),
        .func3_o      (w_func3),
        .func7_o      (w_func7),
        .rd_o         (w_rd),
        .valid_o      (w_valid),
        .ready_i      (r_ready),
        .illegal_o    (w_illegal)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [32];
    exp_t        m_q [$];
    logic        m_illegal;
    int          m_pops;

    int n_tests;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, c_OPC_OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, c_OPC_IMM};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    // Architectural meaning of an instruction, expressed as RV32I rules.
    task automatic model_decode(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, output logic legal, output exp_t e);
        logic [6:0] f7;
        logic [2:0] f3;
        int         imm;
        f7    = ins[31:25];
        f3    = ins[14:12];
        e     = '0;
        e.d1  = m_read(ins[19:15], we, wa, wd);
        e.f3  = f3;
        e.rd  = ins[11:7];
        legal = 1'b0;
        if (ins[6:0] == c_OPC_OP) begin
            legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            e.d2  = m_read(ins[24:20], we, wa, wd);
            e.f7  = f7;
        end else if (ins[6:0] == c_OPC_IMM) begin
            imm = int'(ins[31:20]);
            if (imm >= 2048) imm = imm - 4096;
            e.d2 = 32'(imm);
            if (f3 == 3'd1) begin
                legal = (f7 == 7'h00);
                e.f7  = f7;
            end else if (f3 == 3'd5) begin
                legal = (f7 == 7'h00) || (f7 == 7'h20);
                e.f7  = f7;
            end else begin
                legal = 1'b1;
            end
        end
    endtask

    // One clock: drive at the falling edge, check current outputs, then
    // advance the model to what the next rising edge should produce.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic rdy, input logic fl);
        exp_t e;
        logic legal;
        logic pop;
        logic acc;
        @(negedge clk);
        r_inst_valid = v;
        r_inst       = ins;
        r_wb_en      = we;
        r_wb_addr    = wa;
        r_wb_data    = wd;
        r_ready      = rdy;
        r_flush      = fl;
        #1;
        check_eq("valid_o", 32'(w_valid), 32'(m_q.size() > 0));
        check_eq("inst_ready_o", 32'(w_inst_ready), 32'(m_q.size() < 2));
        check_eq("illegal_o", 32'(w_illegal), 32'(m_illegal));
        if (m_q.size() > 0) begin
            check_eq("data1_o", w_data1, m_q[0].d1);
            check_eq("data2_o", w_data2, m_q[0].d2);
            check_eq("opcode_o", 32'(w_opcode), 32'(c_OPC_OP));
            check_eq("func3_o", 32'(w_func3), 32'(m_q[0].f3));
            check_eq("func7_o", 32'(w_func7), 32'(m_q[0].f7));
            check_eq("rd_o", 32'(w_rd), 32'(m_q[0].rd));
        end
        pop = (m_q.size() > 0) && rdy;
        acc = v && (m_q.size() < 2);
        model_decode(ins, we, wa, wd, legal, e);
        m_illegal = acc && !legal && !fl;
        if (pop) m_pops++;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc && legal) m_q.push_back(e);
        end
        if (we && (wa != 5'd0)) m_regs[wa] = wd;
    endtask

    task automatic issue(input logic [31:0] ins, input logic rdy);
        cycle(1'b1, ins, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        cycle(1'b0, 32'd0, 1'b1, a, d, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_illegal = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"},  32'(w_valid), 32'd0);
        check_eq({tag, "_ready"},  32'(w_inst_ready), 32'd1);
        check_eq({tag, "_illegal"}, 32'(w_illegal), 32'd0);
        check_eq({tag, "_data1"},  w_data1, 32'd0);
        check_eq({tag, "_data2"},  w_data2, 32'd0);
        check_eq({tag, "_opcode"}, 32'(w_opcode), 32'd0);
        check_eq({tag, "_func3"},  32'(w_func3), 32'd0);
        check_eq({tag, "_func7"},  32'(w_func7), 32'd0);
        check_eq({tag, "_rd"},     32'(w_rd), 32'd0);
    endtask

    // Asserts reset between clock edges and checks outputs clear at once.
    task automatic async_reset();
        @(negedge clk);
        r_inst_valid = 1'b0;
        r_wb_en      = 1'b0;
        r_flush      = 1'b0;
        r_ready      = 1'b0;
        #2;
        r_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        r_rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3  = 3'($urandom_range(0, 7));
        logic [11:0] imm = 12'($urandom);
        logic [6:0]  f7;
        int          k   = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (k < 4) return r_type(f7, rs2, rs1, f3, rd);
        if (k < 8) begin
            if ((f3 == 3'd1) || (f3 == 3'd5)) imm[11:5] = f7;
            return i_type(imm, rs1, f3, rd);
        end
        return $urandom;
    endfunction

    initial begin
        int pops_before;
        n_tests      = 0;
        n_fail       = 0;
        m_pops       = 0;
        r_rst_n      = 1'b1;
        r_flush      = 1'b0;
        r_inst       = 32'd0;
        r_inst_valid = 1'b0;
        r_wb_en      = 1'b0;
        r_wb_addr    = 5'd0;
        r_wb_data    = 32'd0;
        r_ready      = 1'b0;
        model_reset();

        #1 r_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        r_rst_n = 1'b1;

        // ADD x1,x5,x6 with x5=7, x6=3
        wb(5'd5, 32'd7);
        wb(5'd6, 32'd3);
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd1), 1'b1);
        idle(1'b1);
        check_eq("add_data1", w_data1, 32'd7);
        check_eq("add_data2", w_data2, 32'd3);
        check_eq("add_rd", 32'(w_rd), 32'd1);

        // ADDI x2,x0,-1 then SRAI x3,x5,4 back to back
        issue(i_type(12'hFFF, 5'd0, 3'd0, 5'd2), 1'b1);
        issue(i_type({7'h20, 5'd4}, 5'd5, 3'd5, 5'd3), 1'b1);
        check_eq("addi_data1", w_data1, 32'd0);
        check_eq("addi_data2", w_data2, 32'hFFFF_FFFF);
        check_eq("addi_func7", 32'(w_func7), 32'd0);
        idle(1'b1);
        check_eq("srai_shamt", 32'(w_data2[4:0]), 32'd4);
        check_eq("srai_func7", 32'(w_func7), 32'h20);
        check_eq("srai_func3", 32'(w_func3), 32'd5);
        check_eq("srai_data1", w_data1, 32'd7);

        // Three back-to-back with the ALU stalled, then release
        pops_before = m_pops;
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd8), 1'b0);
        issue(r_type(7'h20, 5'd6, 5'd5, 3'd0, 5'd9), 1'b0);
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd4, 5'd10), 1'b0);
        check_eq("full_ready_low", 32'(w_inst_ready), 32'd0);
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd4, 5'd10), 1'b1);
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd4, 5'd10), 1'b1);
        idle(1'b1);
        idle(1'b1);
        check_eq("stall_transfers", 32'(m_pops - pops_before), 32'd3);

        // Same-cycle writeback bypass, and x0 stays zero
        cycle(1'b1, r_type(7'h00, 5'd0, 5'd5, 3'd0, 5'd1), 1'b1, 5'd5, 32'd9, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("bypass_data1", w_data1, 32'd9);
        wb(5'd0, 32'd5);
        issue(r_type(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 1'b1);
        idle(1'b1);
        check_eq("x0_data1", w_data1, 32'd0);

        // Illegal instructions
        issue(32'h0000_006F, 1'b1);
        idle(1'b1);
        check_eq("jal_illegal", 32'(w_illegal), 32'd1);
        check_eq("jal_valid", 32'(w_valid), 32'd0);
        idle(1'b1);
        check_eq("jal_pulse_end", 32'(w_illegal), 32'd0);
        issue(r_type(7'h20, 5'd2, 5'd1, 3'd1, 5'd4), 1'b1);
        idle(1'b1);
        check_eq("sub_f3_illegal", 32'(w_illegal), 32'd1);

        // Flush from the full state
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd11), 1'b0);
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd12), 1'b0);
        cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b0);
        check_eq("flush_valid", 32'(w_valid), 32'd0);
        check_eq("flush_ready", 32'(w_inst_ready), 32'd1);

        // Reset while two entries are in flight
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd13), 1'b0);
        issue(r_type(7'h00, 5'd6, 5'd5, 3'd0, 5'd14), 1'b0);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 1) != 0,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
